// File: rtl/glitch_pulse_gen.sv
// glitch_pulse_gen: armed trigger-to-glitch sequencer.
// Once armed, a synchronised rising edge on trigger_in starts a delay of
// delay_cycles clocks, followed by a glitch pulse of width_cycles clocks.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   trigger_in       async target trigger (2-flop synchronised + edge flop)
//   arm / abort      single-cycle arm request / return-to-idle request
//   auto_rearm       level; re-enter ARMED after each completed sequence
//   delay_cycles     trigger-to-pulse delay, sampled at trigger detection
//   width_cycles     pulse width, sampled at trigger detection
//   glitch_out       registered glitch pulse
//   armed / busy     state flags (ARMED / DELAY or PULSE), registered
//   done             one-cycle completion pulse
//   fire_count       completed pulses with non-zero width, wrapping
module glitch_pulse_gen #(
  parameter int unsigned DELAY_W = 32,
  parameter int unsigned WIDTH_W = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               trigger_in,
  input  logic               arm,
  input  logic               abort,
  input  logic               auto_rearm,
  input  logic [DELAY_W-1:0] delay_cycles,
  input  logic [WIDTH_W-1:0] width_cycles,
  output logic               glitch_out,
  output logic               armed,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   fire_count
);

  localparam int unsigned CW = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DELAY = 2'd2,
    ST_PULSE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH_W-1:0] w_q, w_d;
  logic [CNT_W-1:0]   fire_q, fire_d;
  logic               glitch_q, glitch_d;
  logic               armed_q, armed_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               s1_q, s2_q, s3_q;
  logic               trig_rise_c;
  logic               complete_c;

  // Trigger synchroniser plus one extra flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= trigger_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign trig_rise_c = s2_q & ~s3_q;

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      w_q      <= '0;
      fire_q   <= '0;
      glitch_q <= 1'b0;
      armed_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      w_q      <= w_d;
      fire_q   <= fire_d;
      glitch_q <= glitch_d;
      armed_q  <= armed_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state, counter and output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    w_d        = w_q;
    fire_d     = fire_q;
    done_d     = 1'b0;
    complete_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arm) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (trig_rise_c) begin
          w_d = width_cycles;
          if (delay_cycles != '0) begin
            state_d = ST_DELAY;
            cnt_d   = CW'(delay_cycles) - CW'(1);
          end else if (width_cycles != '0) begin
            state_d = ST_PULSE;
            cnt_d   = CW'(width_cycles) - CW'(1);
          end else begin
            complete_c = 1'b1;
          end
        end
      end
      ST_DELAY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (w_q != '0) begin
          state_d = ST_PULSE;
          cnt_d   = CW'(w_q) - CW'(1);
        end else begin
          complete_c = 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Only a non-empty pulse can reach PULSE, so it always counts
          complete_c = 1'b1;
          fire_d     = fire_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (complete_c) begin
      done_d  = 1'b1;
      state_d = auto_rearm ? ST_ARMED : ST_IDLE;
    end

    // Abort overrides everything decided above, including completion
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      fire_d  = fire_q;
      done_d  = 1'b0;
    end
  end

  assign glitch_d = (state_d == ST_PULSE);
  assign armed_d  = (state_d == ST_ARMED);
  assign busy_d   = (state_d == ST_DELAY) || (state_d == ST_PULSE);

  assign glitch_out = glitch_q;
  assign armed      = armed_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fire_count = fire_q;

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Testbench for glitch_pulse_gen: directed scenarios plus randomized
// sequences, checked against edge-number arithmetic derived from the
// trigger edge k (pulse over [k+2+D, k+2+D+W), done at k+2+D+W).
// A 4-bit fire counter keeps the wrap reachable in a short run.
module tb_glitch_pulse_gen;

  localparam int unsigned TB_CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                trigger_in = 1'b0;
  logic                arm = 1'b0;
  logic                abort = 1'b0;
  logic                auto_rearm = 1'b0;
  logic [31:0]         delay_cycles = '0;
  logic [15:0]         width_cycles = '0;
  logic                glitch_out;
  logic                armed;
  logic                busy;
  logic                done;
  logic [TB_CNT_W-1:0] fire_count;

  int unsigned         n_checks = 0;
  int unsigned         n_errors = 0;
  longint              edge_n = 0;

  // Model state between sequences
  bit                  armed_m = 1'b0;
  logic [TB_CNT_W-1:0] fire_m = '0;

  glitch_pulse_gen #(
    .DELAY_W(32),
    .WIDTH_W(16),
    .CNT_W  (TB_CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .trigger_in  (trigger_in),
    .arm         (arm),
    .abort       (abort),
    .auto_rearm  (auto_rearm),
    .delay_cycles(delay_cycles),
    .width_cycles(width_cycles),
    .glitch_out  (glitch_out),
    .armed       (armed),
    .busy        (busy),
    .done        (done),
    .fire_count  (fire_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // One trigger sequence. abort_rel / spur_rel are edge offsets from k
  // (negative = none); arm_mid pulses arm while busy (must be ignored).
  task automatic run_seq(input logic [31:0] d, input logic [15:0] w, input logic au,
                         input int abort_rel, input int spur_rel, input bit arm_mid,
                         input int gap);
    longint k, e, ab, t_end, dl, wl;
    bit     g, b, a, dn;
    logic [TB_CNT_W-1:0] fexp;
    dl = longint'(d);
    wl = longint'(w);
    auto_rearm = au;
    if (!armed_m) begin
      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
      chk("arm_to_armed", 32'(armed), 32'd1);
      armed_m = 1'b1;
    end
    repeat (gap) @(negedge clk);
    delay_cycles = d;
    width_cycles = w;
    trigger_in   = 1'b1;
    k     = edge_n + 1;
    ab    = (abort_rel < 0) ? -1 : k + longint'(abort_rel);
    t_end = (ab >= 0) ? ab + 2 : k + 3 + dl + wl;
    do begin
      @(negedge clk);
      e = edge_n;
      if (ab >= 0 && e >= ab) begin
        g = 0; b = 0; a = 0; dn = 0;
        fexp = fire_m;
      end else begin
        g  = (e >= k + 2 + dl) && (e < k + 2 + dl + wl);
        b  = (e >= k + 2) && (e < k + 2 + dl + wl);
        dn = (e == k + 2 + dl + wl);
        a  = (e < k + 2) ? 1'b1 : ((e >= k + 2 + dl + wl) ? au : 1'b0);
        fexp = (e >= k + 2 + dl + wl && w != 0) ? fire_m + TB_CNT_W'(1) : fire_m;
      end
      chk("glitch_out", 32'(glitch_out), 32'(g));
      chk("busy", 32'(busy), 32'(b));
      chk("armed", 32'(armed), 32'(a));
      chk("done", 32'(done), 32'(dn));
      chk("fire_count", 32'(fire_count), 32'(fexp));
      // Drive inputs for edge e+1
      trigger_in = (spur_rel >= 0) && (e + 1 == k + longint'(spur_rel));
      abort      = (e + 1 == ab);
      arm        = arm_mid && (e + 1 == k + 3);
      if (e >= k + 2) begin
        delay_cycles = $urandom_range(0, 12);
        width_cycles = 16'($urandom_range(0, 6));
      end
    end while (e < t_end);
    if (ab < 0 && w != 0) fire_m = fire_m + TB_CNT_W'(1);
    armed_m = (ab < 0) ? au : 1'b0;
    chk("fire_after_seq", 32'(fire_count), 32'(fire_m));
  endtask

  initial begin
    int unsigned d, w, ab_rel, sp_rel;
    bit          au, am;
    int          tmo;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_glitch", 32'(glitch_out), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fire", 32'(fire_count), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic D=10 W=3 one-shot, then zero-delay cases
    run_seq(32'd10, 16'd3, 1'b0, -1, -1, 1'b0, 4);
    chk("idle_after_oneshot", 32'(armed), 32'd0);
    run_seq(32'd0, 16'd1, 1'b0, -1, -1, 1'b0, 4);
    run_seq(32'd0, 16'd0, 1'b0, -1, -1, 1'b0, 4);

    // Abort in the 2nd cycle of a 5-cycle pulse (pulse starts at k+5)
    run_seq(32'd3, 16'd5, 1'b0, 7, -1, 1'b0, 4);
    repeat (5) begin
      @(negedge clk);
      chk("post_abort_done", 32'(done), 32'd0);
      chk("post_abort_armed", 32'(armed), 32'd0);
    end

    // arm and abort together in IDLE: stays IDLE
    arm = 1'b1; abort = 1'b1;
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    chk("arm_abort_idle", 32'(armed), 32'd0);
    chk("arm_abort_busy", 32'(busy), 32'd0);

    // Trigger while IDLE, then arm: no pulse
    trigger_in = 1'b1;
    @(negedge clk);
    trigger_in = 1'b0;
    repeat (6) @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("idle_trig_glitch", 32'(glitch_out), 32'd0);
      chk("idle_trig_armed", 32'(armed), 32'd1);
    end
    armed_m = 1'b1;

    // Second trigger during DELAY ignored
    run_seq(32'd8, 16'd2, 1'b0, -1, 4, 1'b1, 3);

    // auto_rearm, three triggers ~50 cycles apart
    repeat (3) run_seq(32'd5, 16'd2, 1'b1, -1, -1, 1'b0, 40);
    run_seq(32'd1, 16'd1, 1'b0, -1, -1, 1'b0, 3);

    // Enough back-to-back pulses to wrap the fire counter
    repeat (17) run_seq(32'd0, 16'd1, 1'b1, -1, -1, 1'b0, 3);
    run_seq(32'd0, 16'd1, 1'b0, -1, -1, 1'b0, 3);

    // Maximum delay: aborted after 1000 busy cycles, no underflow
    run_seq(32'hFFFF_FFFF, 16'd4, 1'b0, 1002, -1, 1'b0, 3);

    // Randomized sequences
    repeat (30) begin
      d  = $urandom_range(0, 12);
      w  = $urandom_range(0, 6);
      au = 1'($urandom_range(0, 1));
      ab_rel = 0;
      sp_rel = 0;
      am = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        ab_rel = $urandom_range(1, 2 + d + w);
        run_seq(d, 16'(w), au, int'(ab_rel), -1, 1'b0, int'($urandom_range(3, 8)));
      end else begin
        if (d + w >= 2 && $urandom_range(0, 1) == 1) sp_rel = $urandom_range(2, d + w);
        if (d + w >= 1) am = 1'($urandom_range(0, 1));
        run_seq(d, 16'(w), au, -1, (sp_rel == 0) ? -1 : int'(sp_rel), am,
                int'($urandom_range(3, 8)));
      end
    end

    // Asynchronous reset in the middle of a pulse
    if (armed_m) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    delay_cycles = 32'd2;
    width_cycles = 16'd8;
    repeat (3) @(negedge clk);
    trigger_in = 1'b1;
    @(negedge clk);
    trigger_in = 1'b0;
    tmo = 0;
    while (!glitch_out && tmo < 20) begin
      @(negedge clk);
      tmo++;
    end
    chk("pulse_before_reset", 32'(glitch_out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_glitch", 32'(glitch_out), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_fire", 32'(fire_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst_armed", 32'(armed), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/glitch_pulse_gen.md
# glitch_pulse_gen

Cycle-accurate glitch pulse generator that sits directly downstream of the button-driven delay register. Once armed, it waits for a rising edge on an external target trigger, counts `delay_cycles` clocks (the 32-bit value produced by the front-panel delay adjuster), then drives a registered, glitch-free pulse of `width_cycles` clocks on the glitch output. One-shot by default, with optional automatic re-arm for repeated sweeps.

## Interface
Parameters:
- `DELAY_W`, 32, width of the delay count; matches the delay register output.
- `WIDTH_W`, 16, width of the pulse-width count.
- `CNT_W`, 16, width of the fired-glitch counter.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `trigger_in`  in  1  target trigger, asynchronous to `clk`; internally synchronised by 2 flops.
- `arm`  in  1  single-cycle arm request.
- `abort`  in  1  single-cycle abort; returns the block to IDLE.
- `auto_rearm`  in  1  level; when high, the block re-enters ARMED after each completed glitch.
- `delay_cycles`  in  DELAY_W  trigger-to-pulse delay in clocks; sampled at trigger detection.
- `width_cycles`  in  WIDTH_W  pulse width in clocks; sampled at trigger detection.
- `glitch_out`  out  1  registered glitch pulse.
- `armed`  out  1  high in state ARMED.
- `busy`  out  1  high in states DELAY and PULSE.
- `done`  out  1  one-cycle pulse when a glitch sequence completes.
- `fire_count`  out  CNT_W  number of completed pulses with W>0; wraps at 2^CNT_W.

## Operation
- Trigger path: `s1 <= trigger_in`, `s2 <= s1`, `s3 <= s2`. The rise indication is `trig_rise = s2 & ~s3`. Sync flops reset to 0.
- States: IDLE, ARMED, DELAY, PULSE, encoded as a 2-bit state register.
- IDLE:
  - `arm` moves to ARMED.
  - `trigger_in` is ignored.
- ARMED:
  - `trig_rise` latches D=`delay_cycles` and W=`width_cycles`.
  - If D>0, go to DELAY with `cnt <= D-1`.
  - If D==0 and W>0, go to PULSE with `cnt <= W-1`.
  - If D==0 and W==0, complete immediately (see completion below).
- DELAY:
  - While `cnt != 0`, `cnt <= cnt-1`.
  - At `cnt == 0`: if W>0, go to PULSE with `cnt <= W-1`; otherwise complete.
- PULSE:
  - While `cnt != 0`, `cnt <= cnt-1`.
  - At `cnt == 0`, complete.
- Completion:
  - `done <= 1` for one cycle.
  - `fire_count <= fire_count+1`, only if W>0.
  - Next state is ARMED if `auto_rearm` is high, otherwise IDLE.
- `abort` in any state:
  - Next state is IDLE and `glitch_out` is 0 on the next cycle.
  - No `done`, and `fire_count` is unchanged.
  - Abort has priority over `arm`, `trig_rise` and completion in the same cycle.
- `arm` in ARMED, DELAY or PULSE is ignored.
- `trig_rise` outside ARMED is discarded, not queued.
- `delay_cycles` and `width_cycles` may change at any time. Only the values sampled at trigger detection are used for that sequence.
- `glitch_out` is a flop, set from next-state==PULSE. It has no combinational path to the pin.
- Counters:
  - `cnt` is max(DELAY_W, WIDTH_W) bits, unsigned, and never underflows.
  - D up to 2^32-1 is legal.

## Timing
- Reset values:
  - state IDLE, `glitch_out` 0, `armed` 0, `busy` 0, `done` 0, `fire_count` 0, `cnt` 0, sync flops 0.
  - Assertion of `rst_n` mid-pulse clears `glitch_out` asynchronously.
- Latency, with `trigger_in` rising before edge k:
  - `s1` is set at k, `s2` at k+1, and `trig_rise` is high in the cycle after k+1.
  - The state leaves ARMED at edge k+2.
- `glitch_out` rises at edge k+2+D and stays high for exactly W cycles. It is low again at edge k+2+D+W.
- `done` is high for the single cycle beginning at edge k+2+D+W.
- `busy` covers exactly the DELAY and PULSE cycles.
- With `auto_rearm` high, `armed` rises in the same cycle as `done`, and the next `trig_rise` is accepted from that cycle on.
- Trigger uncertainty: ±1 clk, due to the asynchronous trigger input.
- `arm` to `armed`: 1 cycle.
- `abort` to `glitch_out` low: 1 cycle.

## Test plan
- Reset, `arm`, D=10, W=3, `trigger_in` rises before edge k -> `glitch_out` is high for edges k+12..k+14 exactly, `done` is at k+15, `fire_count`=1, and the block returns to IDLE.
- D=0, W=1 -> a single high cycle at edge k+2; D=0, W=0 -> no pulse, `done` at k+2, `fire_count` unchanged.
- `abort` during PULSE, on the 2nd of 5 cycles -> `glitch_out` is low next cycle, no `done`, IDLE, and `fire_count` unchanged. Simultaneous `arm`+`abort` in IDLE -> the block stays IDLE.
- Trigger in IDLE, then `arm` -> no pulse. A second trigger during DELAY -> ignored, exactly one pulse.
- `auto_rearm`=1, 3 triggers spaced 50 cycles apart, D=5, W=2 -> 3 pulses, `fire_count`=3, and `armed` is high after each `done`.
- `fire_count` preloaded near wrap via 2^16 glitches (or forced) -> 0xFFFF+1 wraps to 0. D=32'hFFFF_FFFF is accepted with no counter underflow, checked with `abort` after 1000 cycles while `busy` is still high.
